// File: rtl/register_status_table_pkg.sv
// Shared definitions for the register status table and its neighbours (RS, ROB).
package register_status_table_pkg;

  localparam int W_ADDR_DEF  = 5;
  localparam int W_TAG_DEF   = 5;
  localparam int N_ENTRY_DEF = 2 ** W_ADDR_DEF;

  typedef logic [W_TAG_DEF-1:0]  tag_t;
  typedef logic [W_ADDR_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/register_status_table_if.sv
// Dispatch / CDB / lookup bus of the register status table.
interface register_status_table_if
  import register_status_table_pkg::*;
#(
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int W_TAG  = W_TAG_DEF
);
  localparam int N_ENTRY = 2 ** W_ADDR;

  logic               dispatch_en;
  logic [W_ADDR-1:0]  dispatch_rdaddr;
  logic [W_TAG-1:0]   dispatch_rdtag;
  logic [W_ADDR-1:0]  dispatch_rsaddr;
  logic [W_ADDR-1:0]  dispatch_rtaddr;
  logic               rst_rsvalid;
  logic [W_TAG-1:0]   rst_rstag;
  logic               rst_rtvalid;
  logic [W_TAG-1:0]   rst_rttag;
  logic               cdb_valid;
  logic [W_TAG-1:0]   cdb_tag;
  logic               flush;
  logic [N_ENTRY-1:0] rst_wen_onehot;
  logic [W_ADDR:0]    rst_pending_cnt;
  logic [W_ADDR-1:0]  debug_addr;
  logic               debug_valid;
  logic [W_TAG-1:0]   debug_tag;

  modport master (
    output dispatch_en, dispatch_rdaddr, dispatch_rdtag, dispatch_rsaddr, dispatch_rtaddr,
    output cdb_valid, cdb_tag, flush, debug_addr,
    input  rst_rsvalid, rst_rstag, rst_rtvalid, rst_rttag,
    input  rst_wen_onehot, rst_pending_cnt, debug_valid, debug_tag
  );

  modport slave (
    input  dispatch_en, dispatch_rdaddr, dispatch_rdtag, dispatch_rsaddr, dispatch_rtaddr,
    input  cdb_valid, cdb_tag, flush, debug_addr,
    output rst_rsvalid, rst_rstag, rst_rtvalid, rst_rttag,
    output rst_wen_onehot, rst_pending_cnt, debug_valid, debug_tag
  );

endinterface

// File: rtl/register_status_table_rst_entry.sv
// One register status entry: pending flag, producer tag, CDB tag match.
module rst_entry
  import register_status_table_pkg::*;
#(
  parameter int W_TAG = W_TAG_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             set_en,
  input  logic [W_TAG-1:0] set_tag,
  input  logic             cdb_valid,
  input  logic [W_TAG-1:0] cdb_tag,
  output logic             valid,
  output logic [W_TAG-1:0] tag,
  output logic             wen
);

  // Producer completes on a matching CDB broadcast unless the pipeline is flushing.
  always_comb begin
    wen = cdb_valid && valid && (tag == cdb_tag) && !flush;
  end

  // Flush beats dispatch, dispatch beats CDB completion (old producer still writes via wen).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (set_en) begin
      valid <= 1'b1;
      tag   <= set_tag;
    end else if (wen) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/register_status_table.sv
// Tomasulo register status table: per-register producer tags, CDB write enables,
// rs/rt/debug lookups and a pending-entry counter.
module register_status_table
  import register_status_table_pkg::*;
#(
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int W_TAG  = W_TAG_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  register_status_table_if.slave  bus
);

  localparam int N_ENTRY = 2 ** W_ADDR;

  logic [N_ENTRY-1:0] valid_vec;
  logic [N_ENTRY-1:0] wen_vec;
  logic [N_ENTRY-1:0] set_vec;
  logic [N_ENTRY-1:0] live_vec;
  logic [W_TAG-1:0]   tag_arr [N_ENTRY];
  logic [W_ADDR:0]    cnt_q;
  logic [W_ADDR:0]    cnt_next;
  logic [W_ADDR:0]    dec_cnt;
  logic               inc;

  // Entry 0 is architecturally never pending.
  assign valid_vec[0] = 1'b0;
  assign wen_vec[0]   = 1'b0;
  assign tag_arr[0]   = '0;

  genvar g;
  generate
    for (g = 1; g < N_ENTRY; g++) begin : g_entry
      rst_entry #(.W_TAG(W_TAG)) u_entry (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .set_en    (set_vec[g]),
        .set_tag   (bus.dispatch_rdtag),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .valid     (valid_vec[g]),
        .tag       (tag_arr[g]),
        .wen       (wen_vec[g])
      );
    end
  endgenerate

  // Decode the dispatch destination into per-entry set strobes (r0 never set).
  always_comb begin
    set_vec = '0;
    for (int unsigned i = 1; i < N_ENTRY; i++) begin
      set_vec[i] = bus.dispatch_en && !bus.flush && (bus.dispatch_rdaddr == W_ADDR'(i));
    end
  end

  // Lookups see same-cycle CDB completion and flush, but not the same-cycle dispatch.
  always_comb begin
    live_vec            = valid_vec & ~wen_vec & {N_ENTRY{~bus.flush}};
    bus.rst_wen_onehot  = wen_vec;
    bus.rst_rsvalid     = live_vec[bus.dispatch_rsaddr];
    bus.rst_rstag       = live_vec[bus.dispatch_rsaddr] ? tag_arr[bus.dispatch_rsaddr] : '0;
    bus.rst_rtvalid     = live_vec[bus.dispatch_rtaddr];
    bus.rst_rttag       = live_vec[bus.dispatch_rtaddr] ? tag_arr[bus.dispatch_rtaddr] : '0;
    bus.debug_valid     = live_vec[bus.debug_addr];
    bus.debug_tag       = live_vec[bus.debug_addr] ? tag_arr[bus.debug_addr] : '0;
    bus.rst_pending_cnt = cnt_q;
  end

  // Counter delta: a dispatch into an idle entry adds one; a CDB clear adds minus one
  // unless a same-cycle dispatch re-occupies that entry.
  always_comb begin
    inc     = bus.dispatch_en && (bus.dispatch_rdaddr != '0) && !valid_vec[bus.dispatch_rdaddr];
    dec_cnt = '0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      dec_cnt = dec_cnt + (W_ADDR+1)'(wen_vec[i] && !set_vec[i]);
    end
    if (bus.flush) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_q + (W_ADDR+1)'(inc) - dec_cnt;
    end
  end

  // Pending-entry counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  a_tag_collision: assert property (@(posedge clk) disable iff (!reset)
    !(bus.dispatch_en && bus.cdb_valid && (bus.dispatch_rdtag == bus.cdb_tag)));

  a_wen_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(wen_vec));

endmodule

// File: tb/tb_register_status_table.sv
module tb_register_status_table;

  localparam int W_ADDR = 5;
  localparam int W_TAG  = 5;
  localparam int N      = 2 ** W_ADDR;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cmp_on = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_status_table_if #(.W_ADDR(W_ADDR), .W_TAG(W_TAG)) bus ();

  register_status_table #(.W_ADDR(W_ADDR), .W_TAG(W_TAG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: which registers await a producer, and which tag.
  logic             mv [N];
  logic [W_TAG-1:0] mt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_wen();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      r[i] = bus.cdb_valid && mv[i] && (mt[i] == bus.cdb_tag) && !bus.flush;
    return r;
  endfunction

  function automatic logic exp_live(input logic [W_ADDR-1:0] a);
    logic [N-1:0] w;
    w = exp_wen();
    return mv[a] && !w[a] && !bus.flush;
  endfunction

  function automatic int model_cnt();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (mv[i]) c++;
    return c;
  endfunction

  // Reference state update at each clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mv[i] <= 1'b0;
        mt[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < N; i++) mv[i] <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.dispatch_en && (bus.dispatch_rdaddr == W_ADDR'(i)) && (i != 0)) begin
          mv[i] <= 1'b1;
          mt[i] <= bus.dispatch_rdtag;
        end else if (bus.cdb_valid && mv[i] && (mt[i] == bus.cdb_tag)) begin
          mv[i] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("wen", 64'(bus.rst_wen_onehot), 64'(exp_wen()));
      chk("cnt", 64'(bus.rst_pending_cnt), 64'(model_cnt()));
      chk("rsvalid", 64'(bus.rst_rsvalid), 64'(exp_live(bus.dispatch_rsaddr)));
      chk("rtvalid", 64'(bus.rst_rtvalid), 64'(exp_live(bus.dispatch_rtaddr)));
      chk("dbgvalid", 64'(bus.debug_valid), 64'(exp_live(bus.debug_addr)));
      if (exp_live(bus.dispatch_rsaddr)) chk("rstag", 64'(bus.rst_rstag), 64'(mt[bus.dispatch_rsaddr]));
      if (exp_live(bus.dispatch_rtaddr)) chk("rttag", 64'(bus.rst_rttag), 64'(mt[bus.dispatch_rtaddr]));
      if (exp_live(bus.debug_addr))      chk("dbgtag", 64'(bus.debug_tag), 64'(mt[bus.debug_addr]));
    end
  end

  task automatic idle();
    bus.dispatch_en     = 1'b0;
    bus.dispatch_rdaddr = '0;
    bus.dispatch_rdtag  = '0;
    bus.dispatch_rsaddr = '0;
    bus.dispatch_rtaddr = '0;
    bus.cdb_valid       = 1'b0;
    bus.cdb_tag         = '0;
    bus.flush           = 1'b0;
    bus.debug_addr      = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int rd, input int tg);
    idle();
    bus.dispatch_en     = 1'b1;
    bus.dispatch_rdaddr = W_ADDR'(rd);
    bus.dispatch_rdtag  = W_TAG'(tg);
    @(negedge clk);
    next();
  endtask

  task automatic rand_cycle();
    int pend [$];
    int freet [$];
    logic tag_used;
    idle();
    bus.flush = ($urandom_range(0, 31) == 0);
    for (int i = 0; i < N; i++) if (mv[i]) pend.push_back(i);
    bus.cdb_valid = ($urandom_range(0, 9) < 7);
    if (pend.size() > 0 && $urandom_range(0, 3) != 0)
      bus.cdb_tag = mt[pend[$urandom_range(0, pend.size() - 1)]];
    else
      bus.cdb_tag = W_TAG'($urandom_range(0, N - 1));
    for (int t = 0; t < 2 ** W_TAG; t++) begin
      tag_used = bus.cdb_valid && (W_TAG'(t) == bus.cdb_tag);
      for (int i = 0; i < N; i++) if (mv[i] && mt[i] == W_TAG'(t)) tag_used = 1'b1;
      if (!tag_used) freet.push_back(t);
    end
    if (freet.size() > 0 && $urandom_range(0, 9) < 6) begin
      bus.dispatch_en     = 1'b1;
      bus.dispatch_rdaddr = W_ADDR'($urandom_range(0, N - 1));
      bus.dispatch_rdtag  = W_TAG'(freet[$urandom_range(0, freet.size() - 1)]);
    end
    bus.dispatch_rsaddr = W_ADDR'($urandom_range(0, N - 1));
    bus.dispatch_rtaddr = W_ADDR'($urandom_range(0, N - 1));
    bus.debug_addr      = W_ADDR'($urandom_range(0, N - 1));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    cmp_on = 1'b1;

    // Reset held with an active CDB tag 0.
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wen", 64'(bus.rst_wen_onehot), 64'h0);
    chk("rst_cnt", 64'(bus.rst_pending_cnt), 64'h0);
    chk("rst_rsvalid", 64'(bus.rst_rsvalid), 64'h0);
    chk("rst_dbgvalid", 64'(bus.debug_valid), 64'h0);
    next();
    reset = 1'b1;
    idle();
    next();

    // Dispatch, lookup, same-cycle CDB completion.
    disp(5, 3);
    idle(); bus.dispatch_rsaddr = 5'd5;
    @(negedge clk);
    chk("t2_rsvalid", 64'(bus.rst_rsvalid), 64'h1);
    chk("t2_rstag", 64'(bus.rst_rstag), 64'h3);
    chk("t2_cnt", 64'(bus.rst_pending_cnt), 64'h1);
    next();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd3;
    @(negedge clk);
    chk("t2_wen", 64'(bus.rst_wen_onehot), 64'h0000_0020);
    chk("t2_rsvalid_cdb", 64'(bus.rst_rsvalid), 64'h0);
    next();
    idle();
    @(negedge clk);
    chk("t2_cnt_after", 64'(bus.rst_pending_cnt), 64'h0);
    next();

    // Rename of r7.
    disp(7, 1);
    idle(); bus.dispatch_en = 1'b1; bus.dispatch_rdaddr = 5'd7; bus.dispatch_rdtag = 5'd2;
    @(negedge clk);
    chk("t3_cnt0", 64'(bus.rst_pending_cnt), 64'h1);
    next();
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1;
    @(negedge clk);
    chk("t3_wen_old", 64'(bus.rst_wen_onehot), 64'h0);
    chk("t3_cnt1", 64'(bus.rst_pending_cnt), 64'h1);
    next();
    bus.cdb_tag = 5'd2;
    @(negedge clk);
    chk("t3_wen_new", 64'(bus.rst_wen_onehot), 64'h0000_0080);
    next();
    idle();
    @(negedge clk);
    chk("t3_cnt2", 64'(bus.rst_pending_cnt), 64'h0);
    next();

    // Same-cycle CDB completion and re-dispatch of r9.
    disp(9, 4);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd4;
    bus.dispatch_en = 1'b1; bus.dispatch_rdaddr = 5'd9; bus.dispatch_rdtag = 5'd6;
    @(negedge clk);
    chk("t4_wen", 64'(bus.rst_wen_onehot), 64'h0000_0200);
    next();
    idle(); bus.dispatch_rsaddr = 5'd9;
    @(negedge clk);
    chk("t4_rsvalid", 64'(bus.rst_rsvalid), 64'h1);
    chk("t4_rstag", 64'(bus.rst_rstag), 64'h6);
    chk("t4_cnt", 64'(bus.rst_pending_cnt), 64'h1);
    next();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd6;
    @(negedge clk);
    next();

    // Dispatch to r0 is a no-op.
    disp(0, 8);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd8;
    @(negedge clk);
    chk("t5_rsvalid", 64'(bus.rst_rsvalid), 64'h0);
    chk("t5_cnt", 64'(bus.rst_pending_cnt), 64'h0);
    chk("t5_wen", 64'(bus.rst_wen_onehot), 64'h0);
    next();

    // Flush with a matching CDB tag.
    disp(1, 10);
    disp(2, 11);
    disp(3, 12);
    idle(); bus.flush = 1'b1; bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd11; bus.dispatch_rsaddr = 5'd2;
    @(negedge clk);
    chk("t6_wen", 64'(bus.rst_wen_onehot), 64'h0);
    chk("t6_rsvalid", 64'(bus.rst_rsvalid), 64'h0);
    chk("t6_cnt_pre", 64'(bus.rst_pending_cnt), 64'h3);
    next();
    idle(); bus.dispatch_rsaddr = 5'd1; bus.dispatch_rtaddr = 5'd2; bus.debug_addr = 5'd3;
    @(negedge clk);
    chk("t6_rsvalid_post", 64'(bus.rst_rsvalid), 64'h0);
    chk("t6_rtvalid_post", 64'(bus.rst_rtvalid), 64'h0);
    chk("t6_dbgvalid_post", 64'(bus.debug_valid), 64'h0);
    chk("t6_cnt_post", 64'(bus.rst_pending_cnt), 64'h0);
    next();

    // Asynchronous reset in the middle of a CDB hit.
    disp(4, 5);
    disp(6, 7);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd5; bus.dispatch_rsaddr = 5'd6;
    #1;
    chk("ar_wen_pre", 64'(bus.rst_wen_onehot), 64'h0000_0010);
    chk("ar_rsvalid_pre", 64'(bus.rst_rsvalid), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_wen", 64'(bus.rst_wen_onehot), 64'h0);
    chk("ar_cnt", 64'(bus.rst_pending_cnt), 64'h0);
    chk("ar_rsvalid", 64'(bus.rst_rsvalid), 64'h0);
    next();
    reset = 1'b1;
    idle();
    next();

    // Randomized traffic checked every cycle by the compare process.
    for (int k = 0; k < 2000; k++) begin
      rand_cycle();
      next();
    end

    idle();
    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
